// File: rtl/multi_approach_signal_ctrl_pkg.sv
// Shared types and lamp codes for the N-approach signal controller.
package sig_ctrl_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2
  } phase_t;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b11;

endpackage

// File: rtl/multi_approach_signal_ctrl_if.sv
// Sensor / lamp bundle of the signal controller.
// Optional preemption inputs exist only when PREEMPT_EN is defined.
interface multi_approach_signal_ctrl_if #(
  parameter int N_APP = 4
);
  localparam int IDX_W = $clog2(N_APP);

  logic [N_APP-1:0]   sensor;
  logic [2*N_APP-1:0] light;
  logic [IDX_W-1:0]   active_idx;
  logic               phase_change;
`ifdef PREEMPT_EN
  logic               preempt;
  logic [IDX_W-1:0]   preempt_idx;
`endif

  // Controller side: consumes sensors, drives lamps.
  modport master (
    input  sensor,
`ifdef PREEMPT_EN
    input  preempt,
    input  preempt_idx,
`endif
    output light,
    output active_idx,
    output phase_change
  );

  // Environment side: drives sensors, observes lamps.
  modport slave (
    output sensor,
`ifdef PREEMPT_EN
    output preempt,
    output preempt_idx,
`endif
    input  light,
    input  active_idx,
    input  phase_change
  );

endinterface

// File: rtl/multi_approach_signal_ctrl_rr_select.sv
// Round-robin finder: first set request strictly after active_idx, wrapping.
module sig_rr_select #(
  parameter int N_APP = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_APP-1:0] req,
  input  logic [IDX_W-1:0] active_idx,
  output logic [IDX_W-1:0] next_idx,
  output logic             any_req
);

  int   cand;
  logic found;

  // Scan offsets 1..N_APP so the current owner is considered last.
  always_comb begin
    next_idx = active_idx;
    any_req  = |req;
    found    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= N_APP; k++) begin
      cand = (int'(active_idx) + k) % N_APP;
      if (!found && req[cand[IDX_W-1:0]]) begin
        next_idx = cand[IDX_W-1:0];
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_approach_signal_ctrl.sv
// N-approach intersection signal controller: round-robin service of latched
// requests with min/max green, fixed yellow and all-red clearance.
// Define PREEMPT_EN to add the preempt / preempt_idx inputs on the bus.
module multi_approach_signal_ctrl
  import sig_ctrl_pkg::*;
#(
  parameter int N_APP       = 4,
  parameter int TIMER_W     = 8,
  parameter int GREEN_MIN   = 20,
  parameter int GREEN_MAX   = 60,
  parameter int YELLOW_T    = 5,
  parameter int ALLRED_T    = 2,
  parameter int DEFAULT_APP = 0
) (
  input logic                         clk,
  input logic                         rst_n,
  multi_approach_signal_ctrl_if.master bus
);

  localparam int IDX_W = $clog2(N_APP);
  localparam logic [2*N_APP-1:0] LIGHT_RST =
    ~({{(2*N_APP-2){1'b0}}, 2'b11} << (2*DEFAULT_APP));

  phase_t             phase_q, phase_d;
  logic [TIMER_W-1:0] counter_q, counter_d;
  logic [IDX_W-1:0]   active_q, active_d;
  logic [N_APP-1:0]   req_q, req_d;
  logic [2*N_APP-1:0] light_q, light_d;
  logic               pc_q, pc_d;

  logic [IDX_W-1:0]   rr_idx, target;
  logic               any_req, leave;
  logic [TIMER_W-1:0] green_cnt;
  logic [N_APP-1:0]   req_set, req_clr;
`ifdef PREEMPT_EN
  logic               preempt_hold, preempt_go;
`endif

  sig_rr_select #(.N_APP(N_APP), .IDX_W(IDX_W)) u_rr (
    .req        (req_q),
    .active_idx (active_q),
    .next_idx   (rr_idx),
    .any_req    (any_req)
  );

  // Next-state: phase sequencing, counter, request latch and lamp decode.
  always_comb begin
    phase_d   = phase_q;
    counter_d = counter_q;
    active_d  = active_q;
    pc_d      = 1'b0;
    req_clr   = '0;
    leave     = 1'b0;
    target    = any_req ? rr_idx : active_q;
    // Count including the cycle now being displayed, so limits are exact lengths.
    green_cnt = (counter_q >= TIMER_W'(GREEN_MAX)) ? counter_q : counter_q + 1'b1;
`ifdef PREEMPT_EN
    preempt_hold = bus.preempt && (bus.preempt_idx == active_q);
    preempt_go   = bus.preempt && !preempt_hold;
    if (bus.preempt) target = bus.preempt_idx;
`endif
    case (phase_q)
      GREEN: begin
        counter_d = green_cnt;
        leave = (green_cnt >= TIMER_W'(GREEN_MIN)) && any_req &&
                (!bus.sensor[active_q] || (green_cnt >= TIMER_W'(GREEN_MAX)));
`ifdef PREEMPT_EN
        if (preempt_hold)    leave = 1'b0;
        else if (preempt_go) leave = 1'b1;
`endif
        if (leave) begin
          phase_d   = YELLOW;
          counter_d = '0;
        end
      end
      YELLOW: begin
        if (counter_q == TIMER_W'(YELLOW_T - 1)) begin
          phase_d   = ALL_RED;
          counter_d = '0;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      ALL_RED: begin
        if (counter_q == TIMER_W'(ALLRED_T - 1)) begin
          phase_d   = GREEN;
          counter_d = '0;
          active_d  = target;
          pc_d      = 1'b1;
          req_clr   = N_APP'(1) << target;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: recover through a clearance interval.
        phase_d   = ALL_RED;
        counter_d = '0;
      end
    endcase

    req_set = bus.sensor & ~(N_APP'(1) << active_q);
    req_d   = (req_q | req_set) & ~req_clr;

    light_d = '1;
    for (int i = 0; i < N_APP; i++) begin
      if (phase_d != ALL_RED && IDX_W'(i) == active_d)
        light_d[2*i +: 2] = (phase_d == GREEN) ? LAMP_GREEN : LAMP_YELLOW;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= GREEN;
      counter_q <= '0;
      active_q  <= IDX_W'(DEFAULT_APP);
      req_q     <= '0;
      light_q   <= LIGHT_RST;
      pc_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      counter_q <= counter_d;
      active_q  <= active_d;
      req_q     <= req_d;
      light_q   <= light_d;
      pc_q      <= pc_d;
    end
  end

  assign bus.light        = light_q;
  assign bus.active_idx   = active_q;
  assign bus.phase_change = pc_q;

endmodule
